fetch_ctrl: RTL
===============

# fetch_ctrl

Sequencing controller for the program counter and instruction fetch stage of the pipelined RISC-V core. It gates processor start, selects the next PC between sequential and redirect targets, and generates the PC write enable from the hazard unit stall, branch redirects and instruction-memory readiness. It holds a redirect that arrives while memory is busy, latches a halt, and counts fetches. It drives the PC register's `pcIn`/`pcWrite` inputs and the IF/ID register's valid/flush.

## Interface
- `PC_STEP`, 4, sequential PC increment in bytes
- `CNT_W`, 32, width of fetch counter
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `startProcess`  in  1  level, enables execution
- `pcCur`  in  32  current PC register value
- `stall`  in  1  hazard-unit stall request (load-use)
- `branchTaken`  in  1  EX-stage redirect strobe, one cycle
- `branchTarget`  in  32  redirect target, valid with `branchTaken`
- `imemReady`  in  1  instruction memory has data for `pcCur`
- `haltReq`  in  1  halt/ecall detected, one cycle
- `pcWrite`  out  1  PC register load enable
- `pcNext`  out  32  value for PC register `pcIn`
- `fetchValid`  out  1  IF/ID may capture the fetched instruction
- `flushIF`  out  1  invalidate IF/ID contents (redirect applied)
- `done`  out  1  processor halted
- `fetchCount`  out  CNT_W  number of PC advances since reset

## Operation
- States: IDLE, RUN, WAIT_MEM, HALTED. Registers: state, `pendValid`, `pendTarget[31:0]`, `fetchCount`.
- Redirect source: `branchTaken` this cycle (priority), else pending register. `redir` = `branchTaken | pendValid`; `redirTarget` = `branchTaken ? branchTarget : pendTarget`.
- `pcNext` = `redir ? redirTarget : pcCur + PC_STEP`. Addition is 32-bit modulo: 0xFFFFFFFC+4 = 0x00000000. Target low bits pass unmodified.
- Active = state RUN, or state WAIT_MEM with `imemReady`=1. This is evaluated identically in both states.
- While active and `imemReady`=1:
  - With `redir`: `pcWrite`=1 and `flushIF`=1, regardless of `stall`. `fetchValid`=0. Clear `pendValid`.
  - Without `redir`: `pcWrite` = `fetchValid` = `~stall`.
- In RUN with `imemReady`=0: `pcWrite`=0 and `fetchValid`=0. Next state is WAIT_MEM. If `branchTaken`, capture `pendTarget`=`branchTarget` and set `pendValid`; a newer `branchTaken` overwrites.
- In WAIT_MEM with `imemReady`=0: hold the state and capture `branchTaken` as in RUN. With `imemReady`=1: advance as above, and next state is RUN.
- In IDLE: all enables are 0. `startProcess`=1 moves to RUN on the next edge. `branchTaken` is ignored.
- `startProcess`=0 in RUN or WAIT_MEM: no `pcWrite` this cycle, next state IDLE, and `pendValid`/`pendTarget` are retained.
- `haltReq`=1 in RUN or WAIT_MEM: it has priority over everything. `pcWrite`, `fetchValid` and `flushIF` are 0 that cycle, `pendValid` is cleared, and next state is HALTED. `haltReq` is ignored in IDLE.
- In HALTED: `done`=1 and all enables are 0. Only `rst` exits this state.
- `fetchCount` increments on every cycle with `pcWrite`=1 and saturates at all-ones.

## Timing
- Enables and `pcNext` are combinational from the current state and inputs. The PC captures `pcNext` on the same edge on which `pcWrite` is sampled high, so PC advance latency is 1 cycle.
- When `startProcess` rises, the first `pcWrite` can occur no earlier than the cycle after the IDLE→RUN edge.
- A pending redirect is applied in the first cycle in which `imemReady`=1.
- Reset values: state IDLE, `pendValid`=0, `pendTarget`=0, `fetchCount`=0, `pcWrite`=0, `fetchValid`=0, `flushIF`=0, `done`=0, `pcNext`=`pcCur`+`PC_STEP`.
- `rst` asserted in any state, including mid-WAIT_MEM or HALTED, returns to the reset values on that edge. Outputs are in reset values from the following cycle.

## Test plan
- Start-up: apply `rst`, keep `imemReady`=1, and hold `startProcess` low for 3 cycles, then raise it. Required: `pcWrite`=0 for those 3 cycles plus the transition cycle. After that, `pcWrite`=1 each cycle, `pcNext` = 0x4, 0x8, 0xC, and `fetchCount` counts 1, 2, 3.
- Stall vs branch: at `pcCur`=0x10, assert `stall` for 2 cycles. Required: `pcWrite`=0 and `pcNext`=0x14. Then assert `stall` and `branchTaken` together with target 0x80. Required: `pcWrite`=1, `flushIF`=1, `pcNext`=0x80.
- Pending redirect: with `imemReady`=0, pulse `branchTaken` with target 0x40, then 2 cycles later pulse it with target 0x60. When `imemReady` returns to 1, required: one `pcWrite` with `pcNext`=0x60 and `flushIF`=1; the next cycle `pcNext`=`pcCur`+4.
- Halt priority: assert `haltReq` and `branchTaken` in the same cycle. Required: `pcWrite`=0, then `done`=1 permanently. `startProcess` toggles and `branchTaken` have no effect until `rst`.
- Wrap and saturation: at `pcCur`=0xFFFFFFFC, required `pcNext`=0x00000000. With `CNT_W`=2, 5 advances leave `fetchCount`=3.
- Mid-operation reset: in WAIT_MEM with `pendValid`=1, assert `rst`. Required: all outputs at reset values, and after restart no stale redirect is applied.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: gates start, picks the next PC, raises the PC
// write enable and IF/ID valid/flush, holds redirects across memory stalls, counts fetches.
module fetch_ctrl #(
    parameter int unsigned PC_STEP = 32'd4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startProcess,
    input  logic [31:0]      pcCur,
    input  logic             stall,
    input  logic             branchTaken,
    input  logic [31:0]      branchTarget,
    input  logic             imemReady,
    input  logic             haltReq,
    output logic             pcWrite,
    output logic [31:0]      pcNext,
    output logic             fetchValid,
    output logic             flushIF,
    output logic             done,
    output logic [CNT_W-1:0] fetchCount
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_MEM = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [31:0]      STEP_C    = 32'(PC_STEP);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1'b1);

    state_t      state_r, state_s;
    logic        pend_valid_r, pend_valid_s;
    logic [31:0] pend_target_r, pend_target_s;
    logic [CNT_W-1:0] fetch_count_r;
    logic        redir_s;
    logic [31:0] redir_target_s;

    // A same-cycle branch outranks a held one; the held target is used until applied.
    always_comb begin
        redir_s        = branchTaken | pend_valid_r;
        redir_target_s = branchTaken ? branchTarget : pend_target_r;
        pcNext         = redir_s ? redir_target_s : (pcCur + STEP_C);
    end

    // Next-state and enable decode; RUN and WAIT_MEM share the same rules.
    always_comb begin
        state_s       = state_r;
        pend_valid_s  = pend_valid_r;
        pend_target_s = pend_target_r;
        pcWrite       = 1'b0;
        fetchValid    = 1'b0;
        flushIF       = 1'b0;
        done          = 1'b0;
        case (state_r)
            IDLE: begin
                if (startProcess) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN, WAIT_MEM: begin
                if (haltReq) begin
                    pend_valid_s = 1'b0;
                    state_s      = HALTED;
                end else if (!startProcess) begin
                    state_s = IDLE;
                end else if (imemReady) begin
                    state_s = RUN;
                    if (redir_s) begin
                        pcWrite      = 1'b1;
                        flushIF      = 1'b1;
                        pend_valid_s = 1'b0;
                    end else begin
                        pcWrite    = ~stall;
                        fetchValid = ~stall;
                    end
                end else begin
                    // Memory busy: remember the newest redirect until data arrives.
                    state_s = WAIT_MEM;
                    if (branchTaken) begin
                        pend_valid_s  = 1'b1;
                        pend_target_s = branchTarget;
                    end else begin
                        pend_valid_s  = pend_valid_r;
                    end
                end
            end
            HALTED: begin
                done    = 1'b1;
                state_s = HALTED;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, pending redirect and saturating fetch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
            fetch_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_s;
            pend_valid_r  <= pend_valid_s;
            pend_target_r <= pend_target_s;
            if (pcWrite && (fetch_count_r != CNT_MAX_C)) begin
                fetch_count_r <= fetch_count_r + CNT_ONE_C;
            end
        end
    end

    assign fetchCount = fetch_count_r;

endmodule
